// File: rtl/frame_rx.sv
// Framed byte-stream receiver: strips preamble/SFD, streams a length-prefixed payload,
// verifies the additive checksum and keeps saturating good/bad frame counters.
module frame_rx #(
   parameter int MIN_PRE = 7,
   parameter int MAX_LEN = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_dv,
   input  logic [7:0]       rxd,
   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_last,
   output logic             frame_good,
   output logic             frame_bad,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] good_cnt,
   output logic [CNT_W-1:0] bad_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_LEN,
      ST_PAY,
      ST_CHK,
      ST_DROP
   } state_t;

   state_t     state, state_n;
   logic [3:0] pre_cnt, pre_cnt_n;
   logic [7:0] len_q, len_n;
   logic [7:0] sum_q, sum_n;
   logic [7:0] cnt_q, cnt_n;
   logic       valid_n, last_n, good_n, bad_n;
   logic [7:0] data_n;
   logic [1:0] err_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         pre_cnt    <= '0;
         len_q      <= '0;
         sum_q      <= '0;
         cnt_q      <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         frame_good <= 1'b0;
         frame_bad  <= 1'b0;
         err_code   <= '0;
      end else begin
         state      <= state_n;
         pre_cnt    <= pre_cnt_n;
         len_q      <= len_n;
         sum_q      <= sum_n;
         cnt_q      <= cnt_n;
         out_valid  <= valid_n;
         out_data   <= data_n;
         out_last   <= last_n;
         frame_good <= good_n;
         frame_bad  <= bad_n;
         err_code   <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      pre_cnt_n = pre_cnt;
      len_n     = len_q;
      sum_n     = sum_q;
      cnt_n     = cnt_q;
      valid_n   = 1'b0;
      data_n    = out_data;
      last_n    = 1'b0;
      good_n    = 1'b0;
      bad_n     = 1'b0;
      err_n     = err_code;
      if (!rx_dv) begin
         // Gap inside a frame is a truncation; a gap anywhere else just re-arms.
         state_n = ST_IDLE;
         if (state inside {ST_PRE, ST_LEN, ST_PAY, ST_CHK}) begin
            bad_n = 1'b1;
            err_n = 2'd2;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (rxd == 8'h55) begin
                  state_n   = ST_PRE;
                  pre_cnt_n = 4'd1;
               end else begin
                  state_n = ST_DROP;
               end
            end
            ST_PRE: begin
               if (rxd == 8'h55) begin
                  if (pre_cnt != 4'hF) pre_cnt_n = pre_cnt + 4'd1;
               end else if (rxd == 8'hD5 && int'(pre_cnt) >= MIN_PRE) begin
                  state_n = ST_LEN;
               end else begin
                  state_n = ST_DROP;
                  bad_n   = 1'b1;
                  err_n   = 2'd1;
               end
            end
            ST_LEN: begin
               len_n = rxd;
               sum_n = rxd;
               cnt_n = '0;
               if (int'(rxd) > MAX_LEN) begin
                  state_n = ST_DROP;
                  bad_n   = 1'b1;
                  err_n   = 2'd1;
               end else if (rxd == 8'h00) begin
                  state_n = ST_CHK;
               end else begin
                  state_n = ST_PAY;
               end
            end
            ST_PAY: begin
               valid_n = 1'b1;
               data_n  = rxd;
               sum_n   = sum_q + rxd;
               cnt_n   = cnt_q + 8'd1;
               if (cnt_q + 8'd1 == len_q) begin
                  last_n  = 1'b1;
                  state_n = ST_CHK;
               end
            end
            ST_CHK: begin
               state_n = ST_DROP;
               if (rxd == sum_q) begin
                  good_n = 1'b1;
               end else begin
                  bad_n = 1'b1;
                  err_n = 2'd3;
               end
            end
            default: state_n = ST_DROP;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         good_cnt <= '0;
         bad_cnt  <= '0;
      end else begin
         if (good_n && good_cnt != '1) good_cnt <= good_cnt + 1'b1;
         if (bad_n && bad_cnt != '1)   bad_cnt  <= bad_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_frame_rx.sv
// Bench for frame_rx: directed frames plus random frames, each parsed by a frame-level
// reference model that predicts every output cycle.
module tb_frame_rx;

   localparam int MIN_PRE = 7;
   localparam int MAX_LEN = 200;
   localparam int CNT_W   = 2;
   localparam int CMAX    = (1 << CNT_W) - 1;
   localparam int NCYC    = 16384;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             rx_dv = 1'b0;
   logic [7:0]       rxd = '0;
   logic             out_valid;
   logic [7:0]       out_data;
   logic             out_last;
   logic             frame_good;
   logic             frame_bad;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] good_cnt;
   logic [CNT_W-1:0] bad_cnt;

   frame_rx #(.MIN_PRE(MIN_PRE), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .rx_dv(rx_dv), .rxd(rxd),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .frame_good(frame_good), .frame_bad(frame_bad), .err_code(err_code),
      .good_cnt(good_cnt), .bad_cnt(bad_cnt)
   );

   always #5 clk = ~clk;

   // Expected outputs, indexed by the input cycle that causes them.
   bit         ev_v[NCYC];
   bit         ev_last[NCYC];
   bit         ev_good[NCYC];
   bit         ev_bad[NCYC];
   logic [7:0] ev_d[NCYC];
   logic [1:0] ev_err[NCYC];

   int         cyc = 0;
   int         checks = 0;
   int         fails = 0;
   int         mg = 0;
   int         mb = 0;
   logic [7:0] fq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic mark_bad(input int idx, input logic [1:0] e);
      ev_bad[idx] = 1'b1;
      ev_err[idx] = e;
   endtask

   // Parse one rx_dv=1 segment starting at cycle t0 the way the wire format defines it.
   task automatic model_frame(input logic [7:0] b[$], input int t0);
      int n, k, len, s, idx, c;
      n = b.size();
      k = 0;
      if (n == 0 || b[0] != 8'h55) return;
      while (k < n && b[k] == 8'h55) k++;
      if (k == n) begin mark_bad(t0 + n, 2'd2); return; end
      if (b[k] != 8'hD5 || ((k > 15) ? 15 : k) < MIN_PRE) begin
         mark_bad(t0 + k, 2'd1);
         return;
      end
      if (k + 1 >= n) begin mark_bad(t0 + n, 2'd2); return; end
      len = int'(b[k+1]);
      if (len > MAX_LEN) begin mark_bad(t0 + k + 1, 2'd1); return; end
      s = len;
      for (int i = 0; i < len; i++) begin
         idx = k + 2 + i;
         if (idx >= n) begin mark_bad(t0 + n, 2'd2); return; end
         ev_v[t0+idx]    = 1'b1;
         ev_d[t0+idx]    = b[idx];
         ev_last[t0+idx] = (i == len - 1);
         s += int'(b[idx]);
      end
      c = k + 2 + len;
      if (c >= n) mark_bad(t0 + n, 2'd2);
      else if (int'(b[c]) == s % 256) ev_good[t0+c] = 1'b1;
      else mark_bad(t0 + c, 2'd3);
   endtask

   task automatic step(input logic dv, input logic [7:0] d);
      rx_dv = dv;
      rxd   = d;
      @(posedge clk);
      #1;
      if (ev_good[cyc] && mg < CMAX) mg++;
      if (ev_bad[cyc] && mb < CMAX) mb++;
      check("out_valid", out_valid, ev_v[cyc]);
      if (ev_v[cyc]) check("out_data", out_data, ev_d[cyc]);
      check("out_last", out_last, ev_last[cyc]);
      check("frame_good", frame_good, ev_good[cyc]);
      check("frame_bad", frame_bad, ev_bad[cyc]);
      if (ev_bad[cyc]) check("err_code", err_code, ev_err[cyc]);
      check("good_cnt", good_cnt, mg);
      check("bad_cnt", bad_cnt, mb);
      cyc++;
   endtask

   task automatic send(input int gap);
      model_frame(fq, cyc);
      foreach (fq[i]) step(1'b1, fq[i]);
      repeat (gap) step(1'b0, 8'($urandom));
   endtask

   task automatic add_pre(input int n);
      repeat (n) fq.push_back(8'h55);
   endtask

   task automatic add_good(input int len);
      int s;
      logic [7:0] p;
      fq.push_back(8'(len));
      s = len;
      for (int i = 0; i < len; i++) begin
         p = 8'($urandom);
         fq.push_back(p);
         s += int'(p);
      end
      fq.push_back(8'(s));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, out_valid, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_last"}, out_last, 0);
      check({tag, "_good"}, frame_good, 0);
      check({tag, "_bad"}, frame_bad, 0);
      check({tag, "_err"}, err_code, 0);
      check({tag, "_gcnt"}, good_cnt, 0);
      check({tag, "_bcnt"}, bad_cnt, 0);
   endtask

   // Asynchronous reset asserted between edges; pending predictions are discarded.
   task automatic mid_reset();
      rst = 1'b1;
      #1;
      check_all_zero("rst_async");
      for (int i = cyc; i < cyc + 64 && i < NCYC; i++) begin
         ev_v[i] = 1'b0; ev_last[i] = 1'b0; ev_good[i] = 1'b0; ev_bad[i] = 1'b0;
      end
      mg = 0;
      mb = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int npre, len, cut, r;
      logic [7:0] sfd;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      step(1'b0, 8'h00);

      // Reference good frame and its corrupted-checksum twin.
      fq = {8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
            8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
      send(1);
      check("ex_good_cnt", good_cnt, 1);
      fq[12] = 8'h0A;
      send(1);
      check("ex_bad_cnt", bad_cnt, 1);

      // Six-byte preamble.
      fq.delete(); add_pre(6);
      fq.push_back(8'hD5); fq.push_back(8'h03); fq.push_back(8'h01);
      send(2);

      // Truncation after two payload bytes of LEN=5.
      fq.delete(); add_pre(7);
      fq.push_back(8'hD5); fq.push_back(8'h05); fq.push_back(8'hAA); fq.push_back(8'hBB);
      send(2);

      // Zero length, then a frame cut by reset in the payload.
      fq.delete(); add_pre(7);
      fq.push_back(8'hD5); fq.push_back(8'h00); fq.push_back(8'h00);
      send(1);
      fq.delete(); add_pre(7);
      fq.push_back(8'hD5); fq.push_back(8'h05); fq.push_back(8'h11); fq.push_back(8'h22);
      model_frame(fq, cyc);
      foreach (fq[i]) step(1'b1, fq[i]);
      mid_reset();
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);

      // Five back-to-back good frames saturate the 2-bit counter.
      repeat (5) begin
         fq.delete(); add_pre(7); fq.push_back(8'hD5); add_good(2);
         send(1);
      end
      check("sat_good_cnt", good_cnt, CMAX);

      // Oversized LEN, noise start, long preamble with trailing bytes after CHK.
      fq.delete(); add_pre(8); fq.push_back(8'hD5); fq.push_back(8'd201);
      fq.push_back(8'h01); send(1);
      fq.delete(); fq.push_back(8'h12); add_pre(8); fq.push_back(8'hD5); add_good(1);
      send(1);
      fq.delete(); add_pre(20); fq.push_back(8'hD5); add_good(4);
      fq.push_back(8'h00); fq.push_back(8'hFF); send(1);

      mid_reset();

      // Random frames with occasional faults.
      while (cyc < NCYC - 400) begin
         fq.delete();
         r = $urandom_range(0, 99);
         if (r < 5) fq.push_back(8'($urandom_range(0, 84)));
         npre = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : $urandom_range(7, 18);
         add_pre(npre);
         sfd = ($urandom_range(0, 14) == 0) ? 8'($urandom) : 8'hD5;
         fq.push_back(sfd);
         r = $urandom_range(0, 99);
         if (r < 8) begin
            fq.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
            fq.push_back(8'($urandom));
         end else begin
            len = (r < 20) ? 0 : $urandom_range(1, 24);
            add_good(len);
            if ($urandom_range(0, 7) == 0) fq[fq.size()-1] = fq[fq.size()-1] + 8'd1;
         end
         if ($urandom_range(0, 5) == 0 && fq.size() > 1) begin
            cut = $urandom_range(1, fq.size() - 1);
            while (fq.size() > cut) void'(fq.pop_back());
         end
         if ($urandom_range(0, 5) == 0)
            repeat ($urandom_range(1, 3)) fq.push_back(8'($urandom));
         send($urandom_range(1, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
